xdma_c2h_pkt_buf: RTL and testbench
===================================

XDMA_C2H_PKT_BUF -- requirements
Module: xdma_c2h_pkt_buf

Interface
REQ-001 The block SHALL have parameter TDATA_WIDTH, default 512, meaning AXIS data width in bits.
REQ-002 The block SHALL have parameter TKEEP_WIDTH, default 64, meaning byte-enable width (TDATA_WIDTH/8).
REQ-003 The block SHALL have parameter DEPTH, default 64, meaning buffer capacity in beats (power of 2, >=4).
REQ-004 The block SHALL have port xdma_clk, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-005 The block SHALL have port xdma_reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports s_axis_tvalid/tready/tlast, 1 bit each (tready output): packet stream in from the UDP RX path.
REQ-007 The block SHALL have ports s_axis_tdata (TDATA_WIDTH), s_axis_tkeep (TKEEP_WIDTH) and s_axis_tuser (1 bit), inputs; tuser=1 on the tlast beat marks a bad packet.
REQ-008 The block SHALL have ports m_axis_tvalid/tlast (1 bit), tdata (TDATA_WIDTH) and tkeep (TKEEP_WIDTH), outputs, plus m_axis_tready, input: the XDMA C2H stream.
REQ-009 The block SHALL have ports pkt_count and drop_count, outputs, 16 bits each: committed-packet and dropped-packet counters.

Function
REQ-010 s_axis_tready SHALL be 1 in every cycle out of reset; the input never back-pressures, and overflow is resolved by dropping.
REQ-011 The write side SHALL be an FSM with states IDLE, ACCEPT and DISCARD.
- IDLE: the first accepted beat goes to ACCEPT if space exists, else to DISCARD.
- A single-beat packet completes in the same cycle and returns to IDLE.
REQ-012 Pointers wr_ptr, wr_commit and rd_ptr SHALL each be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
- Full when wr_ptr-rd_ptr==DEPTH.
- Output data available when rd_ptr!=wr_commit.
REQ-013 In ACCEPT, each beat SHALL be written at wr_ptr, which then increments.
- A beat arriving while full moves the FSM to DISCARD and the beat is not written.
REQ-014 On an accepted tlast beat with tuser=0 and the buffer not full, wr_commit SHALL become wr_ptr+1 in the same cycle and pkt_count SHALL increment, wrapping.
REQ-015 On a tlast beat with tuser=1, or a tlast beat in DISCARD, wr_ptr SHALL be restored to wr_commit, drop_count SHALL increment (saturating at 0xFFFF), and the FSM SHALL return to IDLE.
REQ-016 A packet longer than DEPTH beats SHALL always be dropped.
- No partial packet ever reaches m_axis.
REQ-017 The read side SHALL present output through a registered output stage.
- m_axis_tvalid rises no later than 2 cycles after the committing tlast beat.
REQ-018 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, tkeep and tlast SHALL hold stable.
REQ-019 With m_axis_tready held at 1, the read side SHALL sustain 1 beat per cycle, with no bubbles inside or between committed packets.
REQ-020 Simultaneous read and write in one cycle SHALL be supported.
- Space freed by a read becomes visible to the full check in the following cycle.
REQ-021 Occupancy arithmetic SHALL be an unsigned subtraction over log2(DEPTH)+1 bits.

Reset
REQ-022 On xdma_reset=0, the following SHALL clear asynchronously:
- FSM to IDLE;
- all pointers, pkt_count and drop_count to 0;
- m_axis_tvalid, tlast, tdata and tkeep to 0.
REQ-023 The data memory SHALL have no reset.
REQ-024 Reset asserted mid-packet SHALL discard all buffered and partial data.
- After release, the first beat is treated as a packet start.

Structure
REQ-025 AXIS widths, the DEPTH default and the FSM state enum SHALL reside in the shared XDMA/UDP package.
REQ-026 One sub-module, xdma_c2h_pkt_ram, SHALL hold the simple dual-port DEPTH x (TDATA_WIDTH+TKEEP_WIDTH+1) memory with a registered read.

Verification
REQ-027 Scenario: a 3-beat packet, tkeep=all-ones, last tkeep=0x0000_0000_0000_00FF, tuser=0, m_axis_tready=1 -> identical 3 beats out, first beat within 2 cycles of tlast, pkt_count=1.
REQ-028 Scenario: a 4-beat packet with tuser=1 on tlast, then a 1-beat good packet -> only the 1-beat packet appears, drop_count=1, pkt_count=1.
REQ-029 Scenario: DEPTH=64, m_axis_tready=0, packets of 40 beats then 30 beats -> first packet kept, second dropped (drop_count=1); raising tready then delivers exactly 40 beats.
REQ-030 Scenario: a 65-beat packet with an empty buffer -> dropped, no m_axis_tvalid, wr_ptr equals wr_commit afterwards.
REQ-031 Scenario: m_axis_tready toggling 1/0 each cycle during a 10-beat packet -> output data held stable while stalled, all 10 beats delivered in order.
REQ-032 Scenario: xdma_reset pulsed low at beat 5 of a 10-beat packet -> m_axis_tvalid=0 immediately; a packet after release passes intact with pkt_count=1.

Source files
------------

// File: rtl/xdma_c2h_pkt_buf_pkg.sv
// Shared XDMA/UDP definitions: AXIS widths, buffer depth default and write-side FSM states.
// Latency: none (declarations only).
// Backpressure: n/a.
package xdma_c2h_pkt_buf_pkg;

    localparam int AXIS_TDATA_WIDTH = 512;
    localparam int AXIS_TKEEP_WIDTH = AXIS_TDATA_WIDTH / 8;
    localparam int PKT_BUF_DEPTH    = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCEPT  = 2'd1,
        DISCARD = 2'd2
    } wr_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/xdma_c2h_pkt_buf_if.sv
// AXI-stream bundle used on both sides of the C2H packet buffer.
// Latency: none (wires only).
// Backpressure: tvalid/tready handshake; tuser flags a bad packet on the tlast beat.
interface xdma_c2h_pkt_buf_if
    import xdma_c2h_pkt_buf_pkg::*;
#(
    parameter int TDATA_WIDTH = AXIS_TDATA_WIDTH,
    parameter int TKEEP_WIDTH = AXIS_TKEEP_WIDTH
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TKEEP_WIDTH-1:0] tkeep;
    logic                   tlast;
    logic                   tuser;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser,
        output tready
    );

endinterface

// File: rtl/xdma_c2h_pkt_ram.sv
// Simple dual-port beat memory, one write and one read port, no reset on contents.
// Latency: 1 cycle registered read; rdata holds while re is low.
// Backpressure: none, caller gates we/re.
module xdma_c2h_pkt_ram #(
    parameter int WIDTH = 577,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/xdma_c2h_pkt_buf.sv
// Store-and-forward C2H packet buffer: only complete, good packets reach m_axis.
// Latency: m_axis_tvalid 2 cycles after the committing tlast beat; 1 beat/cycle sustained.
// Backpressure: input never stalls (overflow drops the packet); output holds under tready=0.
module xdma_c2h_pkt_buf
    import xdma_c2h_pkt_buf_pkg::*;
#(
    parameter int TDATA_WIDTH = AXIS_TDATA_WIDTH,
    parameter int TKEEP_WIDTH = AXIS_TKEEP_WIDTH,
    parameter int DEPTH       = PKT_BUF_DEPTH
) (
    input  logic               xdma_clk,
    input  logic               xdma_reset,
    xdma_c2h_pkt_buf_if.slave  s_axis,
    xdma_c2h_pkt_buf_if.master m_axis,
    output logic [15:0]        pkt_count,
    output logic [15:0]        drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    typedef struct packed {
        logic                   tlast;
        logic [TKEEP_WIDTH-1:0] tkeep;
        logic [TDATA_WIDTH-1:0] tdata;
    } beat_t;

    wr_state_t wr_state;
    ptr_t      wr_ptr;
    ptr_t      wr_commit;
    ptr_t      rd_ptr;
    ptr_t      used;
    logic      full;
    logic      avail;
    logic      wr_en;
    beat_t     wr_beat;

    beat_t     ram_q;
    logic      r_vld;
    logic      rd_en;
    logic      load_out;
    logic      m_vld;
    beat_t     m_beat;

    assign s_axis.tready = 1'b1;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign used  = wr_ptr - rd_ptr;
    assign full  = (used == ptr_t'(DEPTH));
    assign avail = (rd_ptr != wr_commit);

    assign wr_en   = s_axis.tvalid && (wr_state != DISCARD) && !full;
    assign wr_beat = '{tlast: s_axis.tlast, tkeep: s_axis.tkeep, tdata: s_axis.tdata};

    always_ff @(posedge xdma_clk or negedge xdma_reset) begin
        if (!xdma_reset) begin
            wr_state   <= IDLE;
            wr_ptr     <= '0;
            wr_commit  <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else if (s_axis.tvalid) begin
            if (s_axis.tlast) begin
                wr_state <= IDLE;
                if (wr_en && !s_axis.tuser) begin
                    wr_ptr    <= wr_ptr + ptr_t'(1);
                    wr_commit <= wr_ptr + ptr_t'(1);
                    pkt_count <= pkt_count + 16'd1;
                end else begin
                    // Rewind over the partial packet; its slots are reused by the next one.
                    wr_ptr     <= wr_commit;
                    drop_count <= sat_inc16(drop_count);
                end
            end else if (wr_en) begin
                wr_ptr   <= wr_ptr + ptr_t'(1);
                wr_state <= ACCEPT;
            end else begin
                wr_state <= DISCARD;
            end
        end
    end

    xdma_c2h_pkt_ram #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (xdma_clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_beat),
        .re    (rd_en),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_q)
    );

    // Two-deep read pipeline (RAM register + output register) keeps full rate under stalls.
    assign load_out = r_vld && (!m_vld || m_axis.tready);
    assign rd_en    = avail && (!r_vld || load_out);

    always_ff @(posedge xdma_clk or negedge xdma_reset) begin
        if (!xdma_reset) begin
            rd_ptr <= '0;
            r_vld  <= 1'b0;
            m_vld  <= 1'b0;
            m_beat <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
                r_vld  <= 1'b1;
            end else if (load_out) begin
                r_vld  <= 1'b0;
            end
            if (load_out) begin
                m_vld  <= 1'b1;
                m_beat <= ram_q;
            end else if (m_axis.tready) begin
                m_vld  <= 1'b0;
            end
        end
    end

    assign m_axis.tvalid = m_vld;
    assign m_axis.tdata  = m_beat.tdata;
    assign m_axis.tkeep  = m_beat.tkeep;
    assign m_axis.tlast  = m_beat.tlast;
    assign m_axis.tuser  = 1'b0;

endmodule

// File: tb/tb_xdma_c2h_pkt_buf.sv
// Scoreboard bench for xdma_c2h_pkt_buf: kept packets are queued at drive time, popped on m_axis.
`timescale 1ns/1ps
module tb_xdma_c2h_pkt_buf;
    import xdma_c2h_pkt_buf_pkg::*;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int CW = 640;

    logic        xdma_clk   = 1'b0;
    logic        xdma_reset = 1'b0;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;

    xdma_c2h_pkt_buf_if #(.TDATA_WIDTH(DW), .TKEEP_WIDTH(KW)) s_if ();
    xdma_c2h_pkt_buf_if #(.TDATA_WIDTH(DW), .TKEEP_WIDTH(KW)) m_if ();

    xdma_c2h_pkt_buf #(
        .TDATA_WIDTH (DW),
        .TKEEP_WIDTH (KW),
        .DEPTH       (64)
    ) dut (
        .xdma_clk   (xdma_clk),
        .xdma_reset (xdma_reset),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    always #5 xdma_clk = ~xdma_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int beats_out = 0;
    int rdy_mode  = 0;
    int exp_pkt   = 0;
    int exp_drop  = 0;
    logic [6:0] exp_commit = '0;
    logic [DW+KW:0]   sb [$];
    logic [DW+KW:0]   exp_w;
    logic [DW+KW+1:0] cur_w;
    logic [DW+KW+1:0] prev_w;
    logic             prev_stall = 1'b0;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // m_axis.tready pattern: 0 always 1, 1 always 0, 2 toggling, 3 random
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge xdma_clk); #1;
            case (rdy_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = 1'b0;
                2:       m_if.tready = ~m_if.tready;
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge xdma_clk) begin
        cur_w = {m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata};
        if (!xdma_reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold", cur_w, prev_w);
            if (m_if.tvalid && m_if.tready) begin
                beats_out++;
                if (sb.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    exp_w = sb.pop_front();
                    check("beat", cur_w[DW+KW:0], exp_w);
                end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_w     = cur_w;
        end
    end

    task automatic send_pkt(input int len, input bit bad, input bit keep,
                            input logic [KW-1:0] last_keep, input int rst_at);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        for (int i = 0; i < len; i++) begin
            @(posedge xdma_clk); #1;
            if (i == rst_at) begin
                xdma_reset = 1'b0;
                s_if.tvalid = 1'b0;
                #1;
                check("rst_mid_vld", m_if.tvalid, 0);
                check("rst_mid_pkt", pkt_count, 0);
                sb.delete();
                exp_pkt = 0; exp_drop = 0; exp_commit = '0;
                @(posedge xdma_clk); #1;
                xdma_reset = 1'b1;
                return;
            end
            for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
            l = (i == len - 1);
            k = l ? last_keep : '1;
            s_if.tvalid = 1'b1;
            s_if.tdata  = d;
            s_if.tkeep  = k;
            s_if.tlast  = l;
            s_if.tuser  = bad && l;
            if (keep) sb.push_back({l, k, d});
        end
        if (keep) begin
            exp_pkt++;
            exp_commit = exp_commit + 7'(len);
        end else begin
            exp_drop++;
        end
    endtask

    task automatic idle();
        @(posedge xdma_clk); #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int c = 0;
        while ((sb.size() != 0 || m_if.tvalid) && c < 2000) begin
            @(negedge xdma_clk);
            c++;
        end
        repeat (4) @(negedge xdma_clk);
        check(tag, sb.size(), 0);
    endtask

    initial begin
        int lat;
        int b0;
        logic [KW-1:0] rk;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        repeat (3) @(posedge xdma_clk); #1;
        check("rst_mvld", m_if.tvalid, 0);
        check("rst_mdata", {m_if.tlast, m_if.tkeep, m_if.tdata}, 0);
        check("rst_pkt", pkt_count, 0);
        check("rst_drop", drop_count, 0);
        xdma_reset = 1'b1;
        @(posedge xdma_clk); #1;
        check("tready", s_if.tready, 1);

        // 3-beat good packet, short last tkeep, latency from tlast
        rdy_mode = 0;
        send_pkt(3, 0, 1, 64'h0000_0000_0000_00FF, -1);
        idle();
        lat = 0;
        while (!m_if.tvalid && lat < 10) begin
            @(posedge xdma_clk); #1;
            lat++;
        end
        check("lat_le2", (lat <= 2) ? 1 : 0, 1);
        drain("t1_drain");
        check("t1_pkt", pkt_count, exp_pkt);
        check("t1_drop", drop_count, exp_drop);

        // bad 4-beat packet followed by a good single beat
        rk = {$urandom, $urandom};
        send_pkt(4, 1, 0, rk, -1);
        send_pkt(1, 0, 1, rk, -1);
        idle();
        drain("t2_drain");
        check("t2_pkt", pkt_count, exp_pkt);
        check("t2_drop", drop_count, exp_drop);

        // oversize packet into an empty buffer
        b0 = beats_out;
        send_pkt(65, 0, 0, '1, -1);
        idle();
        repeat (6) @(negedge xdma_clk);
        check("t3_no_out", beats_out - b0, 0);
        check("t3_wr_ptr", dut.wr_ptr, exp_commit);
        check("t3_wr_commit", dut.wr_commit, exp_commit);
        check("t3_drop", drop_count, exp_drop);

        // overflow with the output stalled: 40 kept, 30 dropped
        rdy_mode = 1;
        b0 = beats_out;
        send_pkt(40, 0, 1, '1, -1);
        send_pkt(30, 0, 0, '1, -1);
        idle();
        repeat (6) @(negedge xdma_clk);
        check("t4_stalled", beats_out - b0, 0);
        check("t4_drop", drop_count, exp_drop);
        check("t4_pkt", pkt_count, exp_pkt);
        rdy_mode = 0;
        drain("t4_drain");
        check("t4_beats", beats_out - b0, 40);

        // toggling tready during a 10-beat packet
        rdy_mode = 2;
        send_pkt(10, 0, 1, {$urandom, $urandom}, -1);
        idle();
        drain("t5_drain");
        rdy_mode = 0;
        check("t5_pkt", pkt_count, exp_pkt);

        // back-to-back mixed packets with random tready
        rdy_mode = 3;
        for (int p = 0; p < 8; p++) begin
            bit bad;
            bad = 1'($urandom_range(0, 2) == 0);
            send_pkt($urandom_range(1, 7), bad, !bad, {$urandom, $urandom}, -1);
        end
        idle();
        drain("t6_drain");
        rdy_mode = 0;
        check("t6_pkt", pkt_count, exp_pkt);
        check("t6_drop", drop_count, exp_drop);

        // reset in the middle of a packet while a committed packet waits on output
        rdy_mode = 1;
        send_pkt(3, 0, 1, '1, -1);
        idle();
        repeat (4) @(posedge xdma_clk); #1;
        check("t7_vld_pre", m_if.tvalid, 1);
        send_pkt(10, 0, 0, '1, 4);
        rdy_mode = 0;
        send_pkt(6, 0, 1, {$urandom, $urandom}, -1);
        idle();
        drain("t7_drain");
        check("t7_pkt", pkt_count, 1);
        check("t7_drop", drop_count, 0);

        check("sb_final", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
